// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Restoring algorithm, one quotient bit per cycle; raises busy as a stall request while working.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]   count;
    logic [1:0]      op_q;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic            q_sign;
    logic            r_sign;

    // Decode of the incoming op at accept time
    logic            in_signed;
    logic            in_is_rem;
    logic            b_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            accept;

    // One restoring step
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] final_val;

    always_comb begin
        in_signed   = ~op[0];
        in_is_rem   = op[1];
        b_zero      = (src_b == '0);
        overflow    = in_signed && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        special     = b_zero || overflow;
        // Overflow DIV returns the dividend itself (most negative value)
        if (b_zero)
            special_val = in_is_rem ? src_a : '1;
        else
            special_val = in_is_rem ? '0 : src_a;
        mag_a  = (in_signed && src_a[XLEN-1]) ? -src_a : src_a;
        mag_b  = (in_signed && src_b[XLEN-1]) ? -src_b : src_b;
        accept = (state == IDLE) && start && !flush;
    end

    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        trial   = shifted - {1'b0, dvs};
        if (!trial[XLEN]) begin
            rem_step = trial[XLEN-1:0];
            quo_step = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_step = shifted[XLEN-1:0];
            quo_step = {quo[XLEN-2:0], 1'b0};
        end
        if (op_q[1])
            final_val = (!op_q[0] && r_sign) ? -rem_step : rem_step;
        else
            final_val = (!op_q[0] && q_sign) ? -quo_step : quo_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_next = special ? DONE : CALC;
                CALC: if (count == '0) state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = !flush && (((state == IDLE) && start) || (state == CALC));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            op_q   <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            q_sign <= 1'b0;
            r_sign <= 1'b0;
            valid  <= 1'b0;
            result <= '0;
        end else begin
            valid <= (state_next == DONE);
            if (accept) begin
                op_q   <= op;
                q_sign <= src_a[XLEN-1] ^ src_b[XLEN-1];
                r_sign <= src_a[XLEN-1];
                rem    <= '0;
                quo    <= mag_a;
                dvs    <= mag_b;
                count  <= CW'(XLEN - 1);
                if (special)
                    result <= special_val;
            end else if (state == CALC && !flush) begin
                rem <= rem_step;
                quo <= quo_step;
                if (count == '0)
                    result <= final_val;
                else
                    count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results popped on each valid pulse,
// plus directed latency, flush, reset and back-to-back checks.
module tb_div_unit;

    localparam int XLEN = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic            clk;
    logic            rst;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    int total = 0;
    int bad   = 0;
    int valid_seen = 0;
    logic [XLEN-1:0] exp_q[$];

    div_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, want);
        end
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && valid === 1'b1) begin
            valid_seen++;
            if (exp_q.size() == 0)
                check("spurious_valid", 32'd1, 32'd0);
            else
                check("result", result, exp_q.pop_front());
        end
    end

    // Issue one op (called just after a rising edge) and follow it to its valid pulse.
    task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] want, input int lat);
        int nb;
        int vc;
        bit ok;
        nb = 0;
        vc = -1;
        ok = 0;
        exp_q.push_back(want);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1;
                vc = i;
                break;
            end
            if (busy) nb++;
            @(posedge clk);
            #1;
            // Forwarding may keep changing operands after accept; must be ignored
            src_a = $urandom;
            src_b = $urandom;
        end
        if (!ok) check("timeout", 32'd0, 32'd1);
        check("busy_cycles", nb, lat);
        check("valid_cycle", vc, lat);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("valid_drop", {31'd0, valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [XLEN-1:0] held;
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;
        int v0;
        bit ok;

        rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; flush = 1'b0;
        #12;
        check("rst_valid",  {31'd0, valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Normal latency and signed cases
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op(OP_DIV,  -32'sd7, 32'd2, 32'hFFFF_FFFD, 33);
        run_op(OP_REM,  -32'sd7, 32'd2, 32'hFFFF_FFFF, 33);
        run_op(OP_DIV,  32'd7, -32'sd2, 32'hFFFF_FFFD, 33);
        run_op(OP_REM,  32'd7, -32'sd2, 32'd1, 33);
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 33);

        // Divide by zero and overflow
        run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op(OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op(OP_DIV,  -32'sd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op(OP_REM,  -32'sd5, 32'd0, 32'hFFFF_FFFB, 1);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Random unsigned and signed ops against native arithmetic
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == '0) rb = 32'd3;
            if (rb == '1) rb = 32'd7;
            case (k % 4)
                0: run_op(OP_DIVU, ra, rb, ra / rb, 33);
                1: run_op(OP_REMU, ra, rb, ra % rb, 33);
                2: run_op(OP_DIV,  ra, rb, $signed(ra) / $signed(rb), 33);
                default: run_op(OP_REM, ra, rb, $signed(ra) % $signed(rb), 33);
            endcase
        end

        // Flush on the 10th CALC cycle
        held  = result;
        v0    = valid_seen;
        start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("flush_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        check("flush_result_held", result, held);
        run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33);
        repeat (30) @(posedge clk);
        #1;
        check("flush_valid_count", valid_seen - v0, 32'd1);

        // Asynchronous reset during CALC
        start = 1'b1; op = OP_DIVU; src_a = 32'd50; src_b = 32'd5;
        repeat (6) @(posedge clk);
        #1;
        start = 1'b0;
        v0 = valid_seen;
        #1 rst = 1'b1;
        #1;
        check("arst_valid",  {31'd0, valid}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_busy",   {31'd0, busy}, 32'd0);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("arst_no_valid", valid_seen - v0, 32'd0);
        run_op(OP_DIVU, 32'd77, 32'd11, 32'd7, 33);

        // Back-to-back with start held high through DONE
        v0 = valid_seen;
        exp_q.push_back(32'd14);
        start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("b2b_timeout1", 32'd0, 32'd1);
        exp_q.push_back(32'd6);
        op = OP_REMU; src_a = 32'd20; src_b = 32'd7;
        @(negedge clk);
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        check("b2b_accept_valid", {31'd0, valid}, 32'd0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("b2b_timeout2", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("b2b_valid_count", valid_seen - v0, 32'd2);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
